// File: rtl/fp_mult_seq_if.sv
// Issue-side bundle for fp_mult_seq: request, operands and rounding mode
// in; busy/done handshake, product and exception flags out.
interface fp_mult_seq_if #(
    parameter int PRECISION = 32
);
    logic                 start;
    logic [PRECISION-1:0] fp_a;
    logic [PRECISION-1:0] fp_b;
    logic [1:0]           rnd_mode;
    logic                 busy;
    logic                 done;
    logic [PRECISION-1:0] result;
    logic                 inv_op;
    logic                 overflow;
    logic                 underflow;
    logic                 inexact;

    modport master (
        output start, fp_a, fp_b, rnd_mode,
        input  busy, done, result,
        input  inv_op, overflow, underflow, inexact
    );

    modport slave (
        input  start, fp_a, fp_b, rnd_mode,
        output busy, done, result,
        output inv_op, overflow, underflow, inexact
    );
endinterface

// File: rtl/fp_mult_seq.sv
// Multi-cycle IEEE-754 multiplier, shift-add mantissa, DAZ/FTZ, 4 rnd modes.
// Ports: clk, reset (async low), bus (start/operands in, busy/done/result/flags out).
module fp_mult_seq #(
    parameter int EXP_SIZE  = 8,
    parameter int MANT_SIZE = 23
) (
    input logic          clk,
    input logic          reset,
    fp_mult_seq_if.slave bus
);
    localparam int PRECISION = 1 + EXP_SIZE + MANT_SIZE;
    localparam int BIAS      = (1 << (EXP_SIZE - 1)) - 1;
    localparam int W         = MANT_SIZE + 1;
    localparam int EW        = EXP_SIZE + 2;
    localparam int CW        = $clog2(W);

    localparam logic [EW-1:0] EXP_MAX  = EW'((1 << EXP_SIZE) - 1);
    localparam logic [EW-1:0] EXP_BIAS = EW'(BIAS);
    localparam logic [CW-1:0] LAST     = CW'(MANT_SIZE);
    localparam logic [PRECISION-1:0] QNAN =
        {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(MANT_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, UNPACK, SPECIAL, MULT, NORM, ROUND, DONE
    } state_t;

    state_t state, state_nx;

    logic [PRECISION-1:0] a_r, b_r, result_r;
    logic [1:0]           rnd_r;
    logic                 sign_r;
    logic [W-1:0]         sig_a;
    logic [2*W-1:0]       prod;
    logic [EW-1:0]        exp_r;
    logic [CW-1:0]        cnt;
    logic [MANT_SIZE-1:0] mant_r;
    logic                 guard_r, sticky_r;
    logic                 inv_r, ovf_r, unf_r, inx_r;

    logic [EXP_SIZE-1:0]  exp_a, exp_b;
    logic [MANT_SIZE-1:0] frac_a, frac_b;
    logic max_a, max_b, zero_a, zero_b;
    logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
    logic is_special;

    assign exp_a  = a_r[PRECISION-2 -: EXP_SIZE];
    assign exp_b  = b_r[PRECISION-2 -: EXP_SIZE];
    assign frac_a = a_r[MANT_SIZE-1:0];
    assign frac_b = b_r[MANT_SIZE-1:0];
    assign max_a  = &exp_a;
    assign max_b  = &exp_b;
    // subnormals count as zero
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign nan_a  = max_a & (|frac_a);
    assign nan_b  = max_b & (|frac_b);
    assign snan_a = nan_a & ~frac_a[MANT_SIZE-1];
    assign snan_b = nan_b & ~frac_b[MANT_SIZE-1];
    assign inf_a  = max_a & ~(|frac_a);
    assign inf_b  = max_b & ~(|frac_b);
    assign is_special = max_a | max_b | zero_a | zero_b;

    logic [PRECISION-1:0] sp_res;
    logic                 sp_inv;

    always_comb begin
        sp_res = {sign_r, {(PRECISION-1){1'b0}}};
        sp_inv = 1'b0;
        if (snan_a | snan_b) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (nan_a | nan_b) begin
            sp_res = QNAN;
        end else if ((inf_a & zero_b) | (inf_b & zero_a)) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
        end else if (inf_a | inf_b) begin
            sp_res = {sign_r, {EXP_SIZE{1'b1}}, {MANT_SIZE{1'b0}}};
        end
    end

    // upper half accumulates while the multiplier shifts out of the low half
    logic [W:0] psum;
    assign psum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, sig_a} : '0);

    logic                 inc, away, ovf, unf, rnd_inx;
    logic [MANT_SIZE:0]   mant_sum;
    logic [EW-1:0]        exp_f;
    logic [PRECISION-1:0] rnd_res;

    always_comb begin
        inc  = 1'b0;
        away = 1'b0;
        unique case (rnd_r)
            2'b00: begin
                inc  = guard_r & (sticky_r | mant_r[0]);
                away = 1'b1;
            end
            2'b01: begin
                inc  = 1'b0;
                away = 1'b0;
            end
            2'b10: begin
                inc  = (guard_r | sticky_r) & ~sign_r;
                away = ~sign_r;
            end
            default: begin
                inc  = (guard_r | sticky_r) & sign_r;
                away = sign_r;
            end
        endcase
        // carry-out leaves the fraction at zero; only the exponent moves
        mant_sum = {1'b0, mant_r} + {{MANT_SIZE{1'b0}}, inc};
        exp_f    = exp_r + {{(EW-1){1'b0}}, mant_sum[MANT_SIZE]};
        ovf      = ~exp_f[EW-1] & (exp_f >= EXP_MAX);
        unf      = exp_f[EW-1] | (exp_f == '0);
        rnd_inx  = guard_r | sticky_r | ovf | unf;
        if (ovf) begin
            rnd_res = away
                ? {sign_r, {EXP_SIZE{1'b1}}, {MANT_SIZE{1'b0}}}
                : {sign_r, {(EXP_SIZE-1){1'b1}}, 1'b0, {MANT_SIZE{1'b1}}};
        end else if (unf) begin
            rnd_res = {sign_r, {(PRECISION-1){1'b0}}};
        end else begin
            rnd_res = {sign_r, exp_f[EXP_SIZE-1:0], mant_sum[MANT_SIZE-1:0]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = UNPACK;
            UNPACK:  state_nx = SPECIAL;
            SPECIAL: state_nx = is_special ? DONE : MULT;
            MULT:    if (cnt == LAST) state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r      <= '0;
            b_r      <= '0;
            rnd_r    <= '0;
            sign_r   <= 1'b0;
            sig_a    <= '0;
            prod     <= '0;
            exp_r    <= '0;
            cnt      <= '0;
            mant_r   <= '0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            result_r <= '0;
            inv_r    <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            inx_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    a_r   <= bus.fp_a;
                    b_r   <= bus.fp_b;
                    rnd_r <= bus.rnd_mode;
                    inv_r <= 1'b0;
                    ovf_r <= 1'b0;
                    unf_r <= 1'b0;
                    inx_r <= 1'b0;
                end
                UNPACK: begin
                    sign_r <= a_r[PRECISION-1] ^ b_r[PRECISION-1];
                    sig_a  <= zero_a ? '0 : {1'b1, frac_a};
                    prod   <= {{W{1'b0}}, (zero_b ? {W{1'b0}} : {1'b1, frac_b})};
                    exp_r  <= {2'b00, exp_a} + {2'b00, exp_b} - EXP_BIAS;
                    cnt    <= '0;
                end
                SPECIAL: if (is_special) begin
                    result_r <= sp_res;
                    inv_r    <= sp_inv;
                end
                MULT: begin
                    prod <= {psum, prod[W-1:1]};
                    cnt  <= cnt + CW'(1);
                end
                NORM: begin
                    // product in [1,4): bit 2W-1 set means one extra integer bit
                    if (prod[2*W-1]) begin
                        mant_r   <= prod[2*W-2 -: MANT_SIZE];
                        guard_r  <= prod[MANT_SIZE];
                        sticky_r <= |prod[MANT_SIZE-1:0];
                        exp_r    <= exp_r + EW'(1);
                    end else begin
                        mant_r   <= prod[2*W-3 -: MANT_SIZE];
                        guard_r  <= prod[MANT_SIZE-1];
                        sticky_r <= |prod[MANT_SIZE-2:0];
                    end
                end
                ROUND: begin
                    result_r <= rnd_res;
                    ovf_r    <= ovf;
                    unf_r    <= unf;
                    inx_r    <= rnd_inx;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE) && (state != DONE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_r;
    assign bus.inv_op    = inv_r;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = unf_r;
    assign bus.inexact   = inx_r;
endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed-vector bench for fp_mult_seq (single precision + half variant).
// Checks results, flags, latency, handshake and mid-operation reset.
module tb_fp_mult_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_mult_seq_if #(.PRECISION(32)) sp_if ();
    fp_mult_seq_if #(.PRECISION(16)) hp_if ();

    fp_mult_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sp_if.slave)
    );

    fp_mult_seq #(.EXP_SIZE(5), .MANT_SIZE(10)) dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (hp_if.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [3:0]  flg;
        bit          spec;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sp_flags();
        return {28'b0, sp_if.inv_op, sp_if.overflow,
                sp_if.underflow, sp_if.inexact};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] rm, input bit hold,
                          output int lat);
        bit acc;
        acc = 1'b0;
        sp_if.fp_a     = a;
        sp_if.fp_b     = b;
        sp_if.rnd_mode = rm;
        sp_if.start    = 1'b1;
        for (int t = 0; t < 4 && !acc; t++) begin
            @(posedge clk);
            #1;
            if (sp_if.busy) acc = 1'b1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept: busy never rose for %h x %h", a, b);
        end
        if (!hold) sp_if.start = 1'b0;
        lat = 1;
        while (!sp_if.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        sp_if.start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  seen;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000, 1'b0};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, 4'b0001, 1'b0};
        vecs[2]  = '{32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, 4'b0001, 1'b0};
        vecs[3]  = '{32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, 4'b0001, 1'b0};
        vecs[4]  = '{32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002, 4'b0001, 1'b0};
        vecs[5]  = '{32'h7F000000, 32'h7F000000, 2'b00, 32'h7F800000, 4'b0101, 1'b0};
        vecs[6]  = '{32'h7F000000, 32'h7F000000, 2'b01, 32'h7F7FFFFF, 4'b0101, 1'b0};
        vecs[7]  = '{32'hFF000000, 32'h7F000000, 2'b10, 32'hFF7FFFFF, 4'b0101, 1'b0};
        vecs[8]  = '{32'hFF000000, 32'h7F000000, 2'b11, 32'hFF800000, 4'b0101, 1'b0};
        vecs[9]  = '{32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[10] = '{32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[11] = '{32'h7FC00000, 32'hBF800000, 2'b00, 32'h7FC00000, 4'b0000, 1'b1};
        vecs[12] = '{32'hFF800000, 32'h40000000, 2'b00, 32'hFF800000, 4'b0000, 1'b1};
        vecs[13] = '{32'h00800000, 32'h3F000000, 2'b00, 32'h00000000, 4'b0011, 1'b0};
        vecs[14] = '{32'h80800000, 32'h3F000000, 2'b00, 32'h80000000, 4'b0011, 1'b0};
        vecs[15] = '{32'h00800000, 32'h3F800000, 2'b00, 32'h00800000, 4'b0000, 1'b0};
        vecs[16] = '{32'h3F800001, 32'h3FC00000, 2'b00, 32'h3FC00002, 4'b0001, 1'b0};
        vecs[17] = '{32'h3F800003, 32'h3FC00000, 2'b00, 32'h3FC00004, 4'b0001, 1'b0};
        vecs[18] = '{32'h3FFFFFFE, 32'h3F800001, 2'b00, 32'h40000000, 4'b0001, 1'b0};
        vecs[19] = '{32'h3FFFFFFE, 32'h3F800001, 2'b01, 32'h3FFFFFFF, 4'b0001, 1'b0};
        vecs[20] = '{32'h00400000, 32'h7F800000, 2'b00, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[21] = '{32'h7FC00000, 32'h7F800001, 2'b00, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[22] = '{32'h80000000, 32'h3F800000, 2'b00, 32'h80000000, 4'b0000, 1'b1};

        sp_if.start = 1'b0;
        sp_if.fp_a = '0;
        sp_if.fp_b = '0;
        sp_if.rnd_mode = '0;
        hp_if.start = 1'b0;
        hp_if.fp_a = '0;
        hp_if.fp_b = '0;
        hp_if.rnd_mode = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(sp_if.busy), 32'd0);
        check("reset done", 32'(sp_if.done), 32'd0);
        check("reset result", sp_if.result, 32'd0);
        check("reset flags", sp_flags(), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, 1'b0, lat);
            check($sformatf("v%0d result", i), sp_if.result, vecs[i].res);
            check($sformatf("v%0d flags", i), sp_flags(), 32'(vecs[i].flg));
            check($sformatf("v%0d latency", i), 32'(lat),
                  vecs[i].spec ? 32'd3 : 32'd29);
            @(posedge clk);
            #1;
            check($sformatf("v%0d done pulse", i), 32'(sp_if.done), 32'd0);
        end

        // start held high for the whole operation
        run_op(32'h3FC00000, 32'h40000000, 2'b00, 1'b1, lat);
        check("held latency", 32'(lat), 32'd29);
        check("held result", sp_if.result, 32'h40400000);
        @(posedge clk);
        #1;
        check("held idle busy", 32'(sp_if.busy), 32'd0);
        @(posedge clk);
        #1;
        check("held no reaccept", 32'(sp_if.busy), 32'd0);

        // reset while in MULT
        sp_if.fp_a = 32'h3F800001;
        sp_if.fp_b = 32'h3F800001;
        sp_if.rnd_mode = 2'b10;
        sp_if.start = 1'b1;
        @(posedge clk);
        #1;
        sp_if.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("midrst busy", 32'(sp_if.busy), 32'd0);
        check("midrst result", sp_if.result, 32'd0);
        check("midrst flags", sp_flags(), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (sp_if.done) seen = 1'b1;
        end
        check("midrst no done", 32'(seen), 32'd0);
        run_op(32'h3F800001, 32'h3F800001, 2'b10, 1'b0, lat);
        check("postrst latency", 32'(lat), 32'd29);
        check("postrst result", sp_if.result, 32'h3F800003);
        check("postrst flags", sp_flags(), 32'd1);

        // half-precision variant
        hp_if.fp_a = 16'h3E00;
        hp_if.fp_b = 16'h4000;
        hp_if.rnd_mode = 2'b00;
        hp_if.start = 1'b1;
        @(posedge clk);
        #1;
        hp_if.start = 1'b0;
        check("half accept", 32'(hp_if.busy), 32'd1);
        lat = 1;
        while (!hp_if.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("half latency", 32'(lat), 32'd16);
        check("half result", 32'(hp_if.result), 32'h4200);
        check("half flags", {28'b0, hp_if.inv_op, hp_if.overflow,
                             hp_if.underflow, hp_if.inexact}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
